// File: rtl/jt51_pkg.sv
// Shared definitions for the jt51 CPU write front end.
// Holds the channel address bases, the default busy length and the strobe selector.
package jt51_pkg;

  localparam logic [7:0] CH_RL_BASE  = 8'h20;
  localparam logic [7:0] CH_KC_BASE  = 8'h28;
  localparam logic [7:0] CH_KF_BASE  = 8'h30;
  localparam logic [7:0] CH_PMS_BASE = 8'h38;

  localparam int BUSY_CYCLES_DEF = 32;

  typedef enum logic [2:0] {
    SEL_RL    = 3'd0,
    SEL_KC    = 3'd1,
    SEL_KF    = 3'd2,
    SEL_PMS   = 3'd3,
    SEL_OTHER = 3'd4
  } sel_e;

  // Each channel register group spans eight addresses, so addr[7:3] picks the group
  function automatic sel_e ch_sel(input logic [7:0] addr);
    sel_e sel;
    case (addr[7:3])
      CH_RL_BASE[7:3]:  sel = SEL_RL;
      CH_KC_BASE[7:3]:  sel = SEL_KC;
      CH_KF_BASE[7:3]:  sel = SEL_KF;
      CH_PMS_BASE[7:3]: sel = SEL_PMS;
      default:          sel = SEL_OTHER;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jt51_busy_cnt.sv
// Busy counter: load starts a window of BUSY_CYCLES cen ticks.
// expire flags the edge on which the window would close, letting the caller reload seamlessly.
module jt51_busy_cnt
  import jt51_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic load,
  output logic busy,
  output logic expire
);

  localparam logic [7:0] LOAD_VAL = 8'(BUSY_CYCLES);

  logic [7:0] cnt_r;
  logic       busy_r;

  assign expire = busy_r & cen & (cnt_r == 8'd1);
  assign busy   = busy_r;

  // Load wins over the decrement so a reload on the expiring edge keeps busy high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= 8'd0;
      busy_r <= 1'b0;
    end else if (load) begin
      cnt_r  <= LOAD_VAL;
      busy_r <= 1'b1;
    end else if (busy_r && cen) begin
      cnt_r <= cnt_r - 8'd1;
      if (cnt_r == 8'd1) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jt51_ch_wr.sv
// YM2151 CPU write front end: address/data latch, channel register decode and busy flag.
// Optional macro JT51_WR_QUEUE_EN adds a one-entry queue for data writes made while busy.
module jt51_ch_wr
  import jt51_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       busy,
  output logic [7:0] dout,
  output logic [2:0] up_ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_other,
  output logic [7:0] up_addr
);

  logic [7:0] addr_q_r;
  logic       data_wr_s;
  logic       busy_s;
  logic       expire_s;
  logic       issue_s;
  logic [7:0] issue_addr_s;
  logic [7:0] issue_data_s;
  sel_e       issue_sel_s;

  assign data_wr_s = wr & a0;
  assign busy      = busy_s;

  jt51_busy_cnt #(
    .BUSY_CYCLES (BUSY_CYCLES)
  ) u_busy_cnt (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .load   (issue_s),
    .busy   (busy_s),
    .expire (expire_s)
  );

`ifdef JT51_WR_QUEUE_EN
  logic       q_valid_r;
  logic [7:0] q_addr_r;
  logic [7:0] q_data_r;
  logic       q_take_s;

  // A write landing on the expiring edge with an empty queue passes straight through
  always_comb begin
    issue_s      = 1'b0;
    issue_addr_s = addr_q_r;
    issue_data_s = din;
    q_take_s     = 1'b0;
    if (!busy_s) begin
      issue_s = data_wr_s;
    end else if (expire_s) begin
      if (q_valid_r) begin
        issue_s      = 1'b1;
        issue_addr_s = q_addr_r;
        issue_data_s = q_data_r;
      end else begin
        issue_s = data_wr_s;
      end
    end else begin
      q_take_s = data_wr_s & ~q_valid_r;
    end
  end

  // Queue holds its own address copy so later address writes cannot retarget it
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid_r <= 1'b0;
      q_addr_r  <= 8'd0;
      q_data_r  <= 8'd0;
    end else if (q_take_s) begin
      q_valid_r <= 1'b1;
      q_addr_r  <= addr_q_r;
      q_data_r  <= din;
    end else if (expire_s && q_valid_r) begin
      q_valid_r <= 1'b0;
    end
  end
`else
  // Without the queue, data writes during busy are simply ignored
  always_comb begin
    issue_s      = data_wr_s & ~busy_s;
    issue_addr_s = addr_q_r;
    issue_data_s = din;
  end
`endif

  // Decode the group of the address being issued this cycle
  always_comb begin
    issue_sel_s = ch_sel(issue_addr_s);
  end

  // Address latch plus registered update strobes; strobes last exactly one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q_r <= 8'd0;
      dout     <= 8'd0;
      up_ch    <= 3'd0;
      up_addr  <= 8'd0;
      up_rl    <= 1'b0;
      up_kc    <= 1'b0;
      up_kf    <= 1'b0;
      up_pms   <= 1'b0;
      up_other <= 1'b0;
    end else begin
      if (wr && !a0) begin
        addr_q_r <= din;
      end
      up_rl    <= 1'b0;
      up_kc    <= 1'b0;
      up_kf    <= 1'b0;
      up_pms   <= 1'b0;
      up_other <= 1'b0;
      if (issue_s) begin
        dout    <= issue_data_s;
        up_addr <= issue_addr_s;
        up_ch   <= issue_addr_s[2:0];
        case (issue_sel_s)
          SEL_RL:  up_rl    <= 1'b1;
          SEL_KC:  up_kc    <= 1'b1;
          SEL_KF:  up_kf    <= 1'b1;
          SEL_PMS: up_pms   <= 1'b1;
          default: up_other <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt51_ch_wr.sv
// Self-checking bench for jt51_ch_wr: directed scenarios plus random traffic
// checked every clk against a behavioural model of the write front end.
module tb_jt51_ch_wr;

  localparam int BC = 4;
`ifdef JT51_WR_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       wr  = 1'b0;
  logic       a0  = 1'b0;
  logic [7:0] din = 8'd0;
  logic       busy;
  logic [7:0] dout;
  logic [2:0] up_ch;
  logic       up_rl, up_kc, up_kf, up_pms, up_other;
  logic [7:0] up_addr;

  always #5 clk = ~clk;

  jt51_ch_wr #(.BUSY_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .a0(a0), .din(din),
    .busy(busy), .dout(dout), .up_ch(up_ch), .up_rl(up_rl), .up_kc(up_kc),
    .up_kf(up_kf), .up_pms(up_pms), .up_other(up_other), .up_addr(up_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_addr = 8'd0;
  logic       m_busy = 1'b0;
  int         m_left = 0;
  logic       qv = 1'b0;
  logic [7:0] qa = 8'd0, qd = 8'd0;
  logic [4:0] e_stb = 5'd0;   // {rl,kc,kf,pms,other}
  logic [7:0] e_dout = 8'd0, e_addr = 8'd0;
  logic [2:0] e_ch = 3'd0;

  function automatic logic [4:0] range_stb(input logic [7:0] a);
    if (a >= 8'h20 && a < 8'h28)      return 5'b10000;
    else if (a >= 8'h28 && a < 8'h30) return 5'b01000;
    else if (a >= 8'h30 && a < 8'h38) return 5'b00100;
    else if (a >= 8'h38 && a < 8'h40) return 5'b00010;
    else                              return 5'b00001;
  endfunction

  task automatic model_step(input logic r, input logic w, input logic a,
                            input logic [7:0] d, input logic c);
    logic       iss;
    logic [7:0] ia, idat;
    iss = 1'b0; ia = 8'd0; idat = 8'd0;
    if (r) begin
      m_addr = 8'd0; m_busy = 1'b0; m_left = 0; qv = 1'b0;
      e_stb = 5'd0; e_dout = 8'd0; e_addr = 8'd0; e_ch = 3'd0;
    end else begin
      e_stb = 5'd0;
      if (w && a) begin
        if (!m_busy) begin
          iss = 1'b1; ia = m_addr; idat = d;
        end else if (QEN && !qv) begin
          qv = 1'b1; qa = m_addr; qd = d;
        end
      end
      if (m_busy && c) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (qv) begin
            iss = 1'b1; ia = qa; idat = qd; qv = 1'b0;
          end else begin
            m_busy = 1'b0;
          end
        end
      end
      if (iss) begin
        m_busy = 1'b1; m_left = BC;
        e_dout = idat; e_addr = ia; e_ch = 3'(ia % 8); e_stb = range_stb(ia);
      end
      if (w && !a) m_addr = d;
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic a,
                     input logic [7:0] d, input logic c);
    @(negedge clk);
    rst = r; wr = w; a0 = a; din = d; cen = c;
    @(posedge clk);
    model_step(r, w, a, d, c);
    #1;
    check("busy", 32'(busy), 32'(m_busy));
    check("strobes", 32'({up_rl, up_kc, up_kf, up_pms, up_other}), 32'(e_stb));
    check("dout", 32'(dout), 32'(e_dout));
    check("up_ch", 32'(up_ch), 32'(e_ch));
    check("up_addr", 32'(up_addr), 32'(e_addr));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || qv || busy) && n < 200) begin
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      n++;
    end
    check("drain_timeout", 32'(n >= 200), 32'd0);
  endtask

  initial begin
    int ticks, cnt, rl_seen;
    logic b_pre, c;
    logic [7:0] d;

    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    check("reset_busy", 32'(busy), 32'd0);

    // Basic KC write
    cyc(1'b0, 1'b1, 1'b0, 8'h2B, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
    check("t1_kc", 32'(up_kc), 32'd1);
    check("t1_only", 32'({up_rl, up_kf, up_pms, up_other}), 32'd0);
    check("t1_ch", 32'(up_ch), 32'd3);
    check("t1_dout", 32'(dout), 32'h5A);
    check("t1_addr", 32'(up_addr), 32'h2B);
    check("t1_busy", 32'(busy), 32'd1);
    drain();

    // Busy length with cen every second clk
    cyc(1'b0, 1'b1, 1'b1, 8'h10, 1'b0);
    ticks = 0;
    for (int i = 1; i < 60; i++) begin
      b_pre = busy;
      c = 1'((i % 2) == 1);
      cyc(1'b0, 1'b0, 1'b0, 8'd0, c);
      if (b_pre && c) ticks++;
      if (!busy) break;
    end
    check("t2_ticks", 32'(ticks), 32'(BC));
    check("t2_busy_low", 32'(busy), 32'd0);

    // PMS write then RL write while busy
    cyc(1'b0, 1'b1, 1'b0, 8'h3F, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h71, 1'b1);
    check("t3_pms", 32'(up_pms), 32'd1);
    check("t3_ch", 32'(up_ch), 32'd7);
    cnt = 1; rl_seen = 0;
    cyc(1'b0, 1'b1, 1'b0, 8'h20, 1'b1);
    if (busy) cnt++;
    cyc(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
    if (busy) cnt++;
    for (int i = 0; i < 40 && busy; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      if (busy) cnt++;
      if (up_rl) begin
        rl_seen++;
        check("t3_rl_dout", 32'(dout), 32'h99);
        check("t3_rl_ch", 32'(up_ch), 32'd0);
      end
    end
    check("t3_busy_clks", 32'(cnt), QEN ? 32'(2 * BC) : 32'(BC));
    check("t3_rl_count", 32'(rl_seen), 32'(QEN));

    // Queued address is not disturbed by a later address write
    cyc(1'b0, 1'b1, 1'b0, 8'h24, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h11, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h30, 1'b1);
    drain();

    // Non-channel address
    cyc(1'b0, 1'b1, 1'b0, 8'h08, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'hC3, 1'b1);
    check("t5_stb", 32'({up_rl, up_kc, up_kf, up_pms, up_other}), 32'b00001);
    check("t5_addr", 32'(up_addr), 32'h08);
    drain();

    // Reset mid-busy with a pending queue entry
    cyc(1'b0, 1'b1, 1'b0, 8'h29, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h01, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h02, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_stb", 32'({up_rl, up_kc, up_kf, up_pms, up_other}), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h31, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h44, 1'b1);
    check("t6_kf", 32'(up_kf), 32'd1);
    drain();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) d = 8'($urandom);
      else d = 8'($urandom_range(8'h20, 8'h3F));
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
